// File: rtl/rx_receiver.sv
// rtl/rx_receiver.sv - UART-style serial receiver (D_BITS data, SP_BITS stop)
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote around every sample point.
module rx_receiver #(
  parameter int clk_speed = 100_000000,
  parameter int baudrate  = 921600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic [D_BITS-1:0] o_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int CPB  = clk_speed / baudrate;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IW   = $clog2(D_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [D_BITS-1:0] shift_q, shift_d;
  logic [D_BITS-1:0] data_q, data_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic              armed_q, armed_d;
  logic              stop_ok_q, stop_ok_d;
  logic              rx_meta_q, rx_s_q;
  logic              sample;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // hist_q[0] is rx_s one cycle before the sample point, hist_q[1] two cycles before.
  logic [1:0] hist_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rx_s_q};
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    armed_d     = armed_q;
    stop_ok_d   = stop_ok_q;
    case (state_q)
      IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!sample) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          // Right shift: after D_BITS samples the first (LSB) sits in bit 0.
          shift_d = {sample, shift_q[D_BITS-1:1]};
          if (idx_q == IW'(D_BITS - 1)) begin
            state_d   = STOP;
            idx_d     = '0;
            stop_ok_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          if (idx_q == IW'(SP_BITS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
            armed_d = 1'b0;
            if (stop_ok_q && sample) begin
              data_d    = shift_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            idx_d     = idx_q + IW'(1);
            stop_ok_d = stop_ok_q & sample;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      stop_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      stop_ok_q   <= stop_ok_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = rx_done_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rx_receiver.sv
// tb/tb_rx_receiver.sv - self-checking bench for rx_receiver (directed + random frames)
module tb_rx_receiver;

  localparam int CLK_SPEED = 100_000000;
  localparam int BAUD      = 921600;
  localparam int DB        = 8;
  localparam int SB        = 1;
  localparam int CPB       = CLK_SPEED / BAUD;
  localparam int HALF      = CPB / 2;
  localparam int LAT       = 2 + HALF + (DB + SB) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] data;
  logic          done;
  logic          ferr;
  logic          busy;

  rx_receiver #(
    .clk_speed(CLK_SPEED),
    .baudrate (BAUD),
    .D_BITS   (DB),
    .SP_BITS  (SB)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (data),
    .o_rx_done  (done),
    .o_frame_err(ferr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int n_sched = 0;
  int n_seen  = 0;
  int last_done_cyc = -1;
  logic [DB-1:0] exp_done[int];
  bit            exp_err[int];
  logic [DB-1:0] model_data = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard: pulses only where the model scheduled them, o_data held otherwise.
  always begin
    @(posedge clk);
    #1;
    if (exp_done.exists(cyc)) begin
      model_data = exp_done[cyc];
      exp_done.delete(cyc);
      check("rx_done_pulse", done, 1);
    end else begin
      check("rx_done_idle", done, 0);
    end
    if (exp_err.exists(cyc)) begin
      exp_err.delete(cyc);
      check("frame_err_pulse", ferr, 1);
    end else begin
      check("frame_err_idle", ferr, 0);
    end
    check("data_hold", data, model_data);
    if (done) begin
      n_seen++;
      last_done_cyc = cyc;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_sched -= exp_done.size();
    exp_done.delete();
    exp_err.delete();
    model_data = '0;
    check("rst_data", data, 0);
    check("rst_done", done, 0);
    check("rst_ferr", ferr, 0);
    check("rst_busy", busy, 0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  // Plays one frame cycle by cycle; level index n is what the DUT sees at edge t0+n.
  task automatic send(input logic [DB-1:0] d, input bit stop_val, input int glitch_at,
                      input int abort_at, input logic [DB-1:0] exp_d, output int t0);
    bit lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < DB; i++) lv.push_back(d[i]);
    for (int i = 0; i < SB; i++) lv.push_back(stop_val);
    t0 = -1;
    for (int n = 0; n < lv.size() * CPB; n++) begin
      if (n == abort_at) return;
      @(negedge clk);
      if (n == 0) begin
        t0 = cyc + 1;
        if (stop_val) begin
          exp_done[t0 + LAT] = exp_d;
          n_sched++;
        end else begin
          exp_err[t0 + LAT] = 1'b1;
        end
      end
      rx = (n == glitch_at) ? 1'b1 : lv[n / CPB];
      if (n == 3 * CPB) begin
        #1;
        check("busy_mid_frame", busy, 1);
      end
    end
  endtask

  initial begin
    int t0;
    int gap;
    logic [DB-1:0] rd;
    bit sv;
    bit prev_bad;

    repeat (3) @(negedge clk);
    check("reset_data", data, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    idle(10);

    send(8'hA5, 1'b1, -1, -1, 8'hA5, t0);
    idle(5);
    check("a5_latency", last_done_cyc - t0, 1028);
    check("a5_data", data, 8'hA5);

    send(8'h00, 1'b1, -1, -1, 8'h00, t0);
    check("b2b_first", data, 8'h00);
    send(8'hFF, 1'b1, -1, -1, 8'hFF, t0);
    check("b2b_second", data, 8'hFF);
    idle(5);

    hold_low(10);
    #1;
    check("glitch_busy_high", busy, 1);
    hold_low(10);
    idle(100);
    #1;
    check("glitch_busy_low", busy, 0);

    send(8'h11, 1'b1, -1, -1, 8'h11, t0);
    send(8'h3C, 1'b0, -1, -1, 8'h3C, t0);
    hold_low(300);
    #1;
    check("break_busy", busy, 0);
    check("break_data", data, 8'h11);
    idle(20);

    send(8'h77, 1'b1, -1, 5 * CPB + 50, 8'h77, t0);
    do_reset(3);
    idle(10);
    send(8'h5A, 1'b1, -1, -1, 8'h5A, t0);
    idle(5);
    check("after_reset_data", data, 8'h5A);

`ifdef RX_MAJORITY_VOTE_EN
    send(8'h00, 1'b1, HALF + 3 * CPB, -1, 8'h00, t0);
    idle(5);
    check("bit2_glitch_data", data, 8'h00);
`else
    send(8'h00, 1'b1, HALF + 3 * CPB, -1, 8'h04, t0);
    idle(5);
    check("bit2_glitch_data", data, 8'h04);
`endif

    prev_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      rd  = DB'($urandom_range(0, 255));
      sv  = ($urandom_range(0, 4) != 0);
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
      if (prev_bad && gap < 2) gap = 2;
      idle(gap);
      send(rd, sv, -1, -1, rd, t0);
      prev_bad = !sv;
    end

    idle(LAT + 50);
    check("pulse_count", n_seen, n_sched);
    check("pending_done", exp_done.size(), 0);
    check("pending_err", exp_err.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_receiver.md
RX_RECEIVER -- requirements
Module: rx_receiver

Interface
REQ-001 SHALL have parameter clk_speed, default 100_000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baudrate, default 921600, serial line bit rate.
REQ-003 SHALL have parameter D_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter SP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have port i_clk, input, 1, single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port i_rx, input, 1, asynchronous serial line, idle high, LSB-first 8N1-style frames from the transmitter.
REQ-008 SHALL have port o_data, output, D_BITS, last correctly framed byte.
REQ-009 SHALL have port o_rx_done, output, 1, one-cycle pulse when o_data is updated.
REQ-010 SHALL have port o_frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port o_busy, output, 1, high while a frame is in progress.

Function
REQ-012 SHALL derive CPB = clk_speed/baudrate (integer floor, 108 at defaults) and HALF = CPB/2 (54).
REQ-013 SHALL pass i_rx through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP with a bit-period counter and a bit index.
REQ-015 IDLE: SHALL go to START, counter 0, when armed and rx_s == 0; o_busy = 0 only in IDLE.
REQ-016 IDLE arming: SHALL require rx_s == 1 for at least one cycle after reset or after leaving STOP, so a held-low line (break) never retriggers.
REQ-017 START: at counter == HALF-1, SHALL sample the line. If 0, go to DATA with counter 0 and index 0. If 1, treat as a glitch: go to IDLE with no pulse.
REQ-018 DATA: at counter == CPB-1, SHALL shift the sample into bit [index] (LSB first) and clear the counter. After bit D_BITS-1, go to STOP.
REQ-019 STOP: SHALL sample each of SP_BITS stop bits at counter == CPB-1. After the last one, go to IDLE.
REQ-020 If all stop samples are 1, SHALL load o_data and pulse o_rx_done for exactly 1 cycle.
REQ-021 If any stop sample is 0, SHALL pulse o_frame_err for 1 cycle and leave o_data unchanged.
REQ-022 o_rx_done and o_frame_err SHALL never be high in the same cycle.
REQ-023 Latency: o_rx_done SHALL rise 2 + HALF + (D_BITS+SP_BITS)*CPB cycles after the first cycle i_rx is low at the i_clk edge (1028 at defaults).
REQ-024 Back-to-back frames: a start bit beginning immediately after the stop-bit sample point SHALL be received with no loss.
REQ-025 SHALL hold o_data stable between o_rx_done pulses.

Reset
REQ-026 i_rst SHALL asynchronously force IDLE (unarmed), counter 0, index 0, shift register 0, o_data 0, o_rx_done 0, o_frame_err 0, o_busy 0.
REQ-027 Reset mid-frame SHALL abort the frame with no pulse. The next full frame after deassertion and line-high arming SHALL be received correctly.

Configuration
REQ-028 Macro RX_MAJORITY_VOTE_EN: when defined, every sample point (START, DATA, STOP) SHALL use the 2-of-3 majority of rx_s at counter values point-2, point-1 and point. Latency is unchanged.
REQ-029 Without RX_MAJORITY_VOTE_EN, SHALL use the single rx_s value at the sample point, and no vote logic is present.

Verification
REQ-030 Defaults, reset released, line idle, frame 0xA5 driven at 108 clk/bit -> o_rx_done pulses once, 1028 cycles after the start edge; o_data = 0xA5; o_frame_err never set.
REQ-031 Frames 0x00 then 0xFF back-to-back with no idle gap -> two o_rx_done pulses; o_data = 0x00, then 0xFF.
REQ-032 i_rx low for 20 cycles, then high -> o_busy rises then returns low at the START check; no pulse on either output.
REQ-033 Frame 0x3C with stop bit driven 0, after a prior good 0x11 -> o_frame_err pulses once; o_data stays 0x11. Line held low afterwards -> no new frame until the line returns high.
REQ-034 i_rst asserted during data bit 4 of 0x77 -> all outputs 0 immediately. Next frame 0x5A -> o_data = 0x5A with one o_rx_done pulse.
REQ-035 One-cycle high glitch on i_rx exactly at the bit-2 sample point of 0x00. With RX_MAJORITY_VOTE_EN -> o_data = 0x00. Without it -> o_data = 0x04.
